// File: rtl/dkong_audio_post.sv
// ============================================================================
// Module   : dkong_audio_post
// Brief    : 48 kHz audio post-processing for the dkong_top 8-bit sound bus:
//            sample tick, mute, one-pole low-pass, optional DC block
//            (macro DKONG_AUDIO_DCBLOCK_EN), volume scale and saturation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dkong_audio_post #(
    parameter int DIV      = 512,
    parameter int LP_SHIFT = 2
) (
    input  logic               I_CLK_24576M,
    input  logic               I_RESETn,
    input  logic [7:0]         I_SND_DAT,
    input  logic               I_MUTE,
    input  logic [1:0]         I_VOL,
    output logic signed [15:0] O_AUDIO,
    output logic               O_SAMPLE_STB
);

    localparam logic [15:0] CNT_MAX = 16'(DIV - 1);

    logic [15:0]        cnt;
    logic               tick_q;
    logic               s_vld;
    logic               lp_vld;
    logic signed [15:0] s;
    logic signed [15:0] lp;
    logic signed [16:0] diff;
    logic signed [16:0] diff_sh;
    logic signed [17:0] d;
    logic signed [17:0] scaled;
    logic signed [15:0] sat;

    // Sample-rate divider plus one-hot valid chain: tick -> s -> lp -> out.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            cnt    <= '0;
            tick_q <= 1'b0;
            s_vld  <= 1'b0;
            lp_vld <= 1'b0;
        end else begin
            cnt    <= (cnt == CNT_MAX) ? 16'd0 : cnt + 16'd1;
            tick_q <= (cnt == CNT_MAX);
            s_vld  <= tick_q;
            lp_vld <= s_vld;
        end
    end

    // Flipping the MSB turns offset-binary 0x80-silence into signed zero.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            s <= '0;
        end else if (tick_q) begin
            s <= I_MUTE ? 16'sd0 : {~I_SND_DAT[7], I_SND_DAT[6:0], 8'h00};
        end
    end

    assign diff    = {s[15], s} - {lp[15], lp};
    assign diff_sh = diff >>> LP_SHIFT;

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            lp <= '0;
        end else if (s_vld) begin
            lp <= lp + 16'(diff_sh);
        end
    end

`ifdef DKONG_AUDIO_DCBLOCK_EN
    logic signed [17:0] hp;
    logic signed [15:0] lp_prev;
    logic signed [17:0] lp_ext;
    logic signed [17:0] lp_prev_ext;
    logic signed [17:0] hp_shr;
    logic signed [17:0] hp_next;

    assign lp_ext      = {{2{lp[15]}}, lp};
    assign lp_prev_ext = {{2{lp_prev[15]}}, lp_prev};
    assign hp_shr      = hp >>> 8;
    assign hp_next     = lp_ext - lp_prev_ext + hp - hp_shr;
    // The freshly computed high-pass value feeds this same output edge.
    assign d           = hp_next;

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            hp      <= '0;
            lp_prev <= '0;
        end else if (lp_vld) begin
            hp      <= hp_next;
            lp_prev <= lp;
        end
    end
`else
    assign d = {{2{lp[15]}}, lp};
`endif

    always_comb begin
        scaled = d;
        case (I_VOL)
            2'd0:    scaled = d >>> 2;
            2'd1:    scaled = d >>> 1;
            2'd2:    scaled = d;
            default: scaled = d <<< 1;
        endcase
    end

    always_comb begin
        sat = 16'(scaled);
        if (scaled > 18'sd32767) begin
            sat = 16'sh7FFF;
        end else if (scaled < -18'sd32768) begin
            sat = 16'sh8000;
        end
    end

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_AUDIO      <= '0;
            O_SAMPLE_STB <= 1'b0;
        end else begin
            O_SAMPLE_STB <= lp_vld;
            if (lp_vld) begin
                O_AUDIO <= sat;
            end
        end
    end

endmodule

`default_nettype wire
